// File: rtl/agu_param_top.sv
`default_nettype none
// ============================================================================
//  Module      : agu_param_top
//  Description : Parametrised NWC NTT address-generation unit. Each beat it
//                issues LANES conflict-free coefficient orders for the current
//                radix-LANES stage and translates them to memory address (MA)
//                and bank number (BN). Forward/inverse stage order, ready/valid
//                output with full backpressure, per-stage last marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module agu_param_top #(
    parameter  int LOG_N   = 12,
    parameter  int LOG_L   = 4,
    localparam int LANES   = 1 << LOG_L,
    localparam int NUM_STG = LOG_N / LOG_L,
    localparam int MA_W    = LOG_N - LOG_L
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   inverse,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [LANES*MA_W-1:0]  ma_idx,
    output logic [LANES*LOG_L-1:0] bn_idx,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy
);

    // Stage digits must tile the index exactly and leave a non-empty MA field.
    generate
        if (((LOG_N % LOG_L) != 0) || (LOG_N <= LOG_L)) begin : g_param_check
            $error("agu_param_top: LOG_N must be a multiple of LOG_L and larger than it");
        end
    endgenerate

    localparam int STG_W = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;
    localparam int SH_W  = $clog2(LOG_N + 1);
    localparam logic [STG_W-1:0] c_LAST_STG = STG_W'(NUM_STG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_inv;
    logic [STG_W-1:0]  r_stage;
    logic [MA_W-1:0]   r_cnt;

    // Generate-stage pipeline registers
    logic              r_g_valid;
    logic [STG_W-1:0]  r_g_stage;
    logic [MA_W-1:0]   r_g_cnt;
    logic              r_g_last;
    logic              r_g_final;

    // Translate-stage companion of out_last: marks the last beat of the run
    logic              r_o_final;

    logic                   w_stall;
    logic                   w_stg_final;
    logic                   w_cnt_wrap;
    logic [SH_W-1:0]        w_sh;
    logic [LANES*MA_W-1:0]  w_ma;
    logic [LANES*LOG_L-1:0] w_bn;

    // A presented beat that is not taken freezes the whole pipe and generator.
    assign w_stall     = out_valid & ~out_ready;
    assign w_stg_final = r_inv ? (r_stage == '0) : (r_stage == c_LAST_STG);
    assign w_cnt_wrap  = &r_cnt;
    assign done        = out_valid & out_ready & r_o_final;
    assign busy        = (r_state != ST_IDLE);

    // Control FSM and beat counters for the generator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_inv   <= 1'b0;
            r_stage <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_inv   <= inverse;
                        r_stage <= inverse ? c_LAST_STG : '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_stall) begin
                        r_cnt <= r_cnt + MA_W'(1);
                        if (w_cnt_wrap) begin
                            if (w_stg_final) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_stage <= r_inv ? (r_stage - STG_W'(1))
                                                 : (r_stage + STG_W'(1));
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Generate stage: capture (stage, count) of the beat being issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g_valid <= 1'b0;
            r_g_stage <= '0;
            r_g_cnt   <= '0;
            r_g_last  <= 1'b0;
            r_g_final <= 1'b0;
        end else if (!w_stall) begin
            r_g_valid <= (r_state == ST_RUN);
            r_g_stage <= r_stage;
            r_g_cnt   <= r_cnt;
            r_g_last  <= (r_state == ST_RUN) && w_cnt_wrap;
            r_g_final <= (r_state == ST_RUN) && w_cnt_wrap && w_stg_final;
        end
    end

    // Bit position of the stage digit inside the index
    assign w_sh = SH_W'(r_g_stage) * SH_W'(LOG_L);

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [LOG_N-1:0] w_cnt_ext;
            logic [LOG_N-1:0] w_mask;
            logic [LOG_N-1:0] w_idx;
            logic [LOG_L-1:0] w_sum;

            // Insert lane number as digit s of the count; BN is the digit sum
            always_comb begin
                w_cnt_ext = LOG_N'(r_g_cnt);
                w_mask    = (LOG_N'(1) << w_sh) - LOG_N'(1);
                // The high part of the count moves up one digit to make room.
                w_idx     = ((w_cnt_ext & ~w_mask) << LOG_L)
                          | (LOG_N'(j) << w_sh)
                          | (w_cnt_ext & w_mask);
                w_sum     = '0;
                for (int k = 0; k < NUM_STG; k++) begin
                    w_sum = w_sum + w_idx[k*LOG_L +: LOG_L];
                end
            end

            assign w_ma[j*MA_W +: MA_W]   = w_idx[LOG_N-1:LOG_L];
            assign w_bn[j*LOG_L +: LOG_L] = w_sum;
        end
    endgenerate

    // Translate stage: registered outputs, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ma_idx    <= '0;
            bn_idx    <= '0;
            out_last  <= 1'b0;
            r_o_final <= 1'b0;
        end else if (!w_stall) begin
            out_valid <= r_g_valid;
            ma_idx    <= r_g_valid ? w_ma : '0;
            bn_idx    <= r_g_valid ? w_bn : '0;
            out_last  <= r_g_last;
            r_o_final <= r_g_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_agu_param_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agu_param_top
//  Description : Self-checking bench for agu_param_top. One instance with
//                LOG_N=8 for the directed sequences, one with default
//                parameters for the randomized-backpressure run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agu_param_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic inverse = 1'b0;
    logic out_ready = 1'b0;
    logic sel = 1'b0;          // 0: LOG_N=8 instance, 1: LOG_N=12 instance

    logic        start8, start12;
    logic        v8, last8, done8, busy8;
    logic [63:0] ma8, bn8;
    logic        v12, last12, done12, busy12;
    logic [127:0] ma12;
    logic [63:0]  bn12;

    logic         obs_v, obs_last, obs_done, obs_busy;
    logic [127:0] obs_ma;
    logic [63:0]  obs_bn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start8   = start & ~sel;
    assign start12  = start & sel;
    assign obs_v    = sel ? v12    : v8;
    assign obs_last = sel ? last12 : last8;
    assign obs_done = sel ? done12 : done8;
    assign obs_busy = sel ? busy12 : busy8;
    assign obs_ma   = sel ? ma12   : {64'b0, ma8};
    assign obs_bn   = sel ? bn12   : bn8;

    agu_param_top #(.LOG_N(8), .LOG_L(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .inverse(inverse),
        .out_ready(out_ready), .out_valid(v8), .ma_idx(ma8), .bn_idx(bn8),
        .out_last(last8), .done(done8), .busy(busy8)
    );

    agu_param_top u_dut12 (
        .clk(clk), .rst(rst), .start(start12), .inverse(inverse),
        .out_ready(out_ready), .out_valid(v12), .ma_idx(ma12), .bn_idx(bn12),
        .out_last(last12), .done(done12), .busy(busy12)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: lane j's order is count c with digit j inserted at base-16
    // position s; MA drops the lowest digit, BN is the digit sum mod 16.
    function automatic void model(input int log_n, input int s, input int c,
                                  output logic [127:0] ema, output logic [63:0] ebn);
        int p, idx, t, sum;
        ema = '0;
        ebn = '0;
        p = 1;
        for (int i = 0; i < s; i++) p = p * 16;
        for (int j = 0; j < 16; j++) begin
            idx = (c / p) * p * 16 + j * p + (c % p);
            t = idx;
            sum = 0;
            for (int d = 0; d < log_n / 4; d++) begin
                sum = sum + t % 16;
                t = t / 16;
            end
            ema = ema | (128'(idx / 16) << (j * (log_n - 4)));
            ebn = ebn | (64'(sum % 16) << (j * 4));
        end
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, 128'(obs_v), 128'(0));
        chk({tag, "_ma"},    obs_ma, 128'(0));
        chk({tag, "_bn"},    128'(obs_bn), 128'(0));
        chk({tag, "_last"},  128'(obs_last), 128'(0));
        chk({tag, "_done"},  128'(obs_done), 128'(0));
        chk({tag, "_busy"},  128'(obs_busy), 128'(0));
    endtask

    // One transform run. stall_at/rst_at < 0 disable those events.
    task automatic run(input bit use12, input bit inv, input int stall_at, input int stall_len,
                       input int rst_at, input bit rnd, input bit hold);
        int log_n = use12 ? 12 : 8;
        int nst   = use12 ? 3 : 2;
        int bps   = use12 ? 256 : 16;
        int total = nst * bps;
        int limit = total * 6 + 20;
        int k = 0, cyc = 0, stalled = 0, first = -1, done_cyc = -1;
        int sidx, s, c;
        bit fin = 0, acc, rst_hit = 0;
        logic [127:0] ema;
        logic [63:0]  ebn;
        logic [15:0]  seen;

        sel = use12;
        @(posedge clk); #1;
        start = 1'b1; inverse = inv; out_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        inverse = ~inv;                       // must only matter at start
        chk("busy_after_start", 128'(obs_busy), 128'(1));

        while (!fin && cyc < limit) begin
            @(posedge clk); cyc++; #1;
            if (rnd) out_ready = ($urandom_range(3, 0) != 0);
            else if (stall_at >= 0 && k == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else out_ready = 1'b1;
            #1;
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b1;
                #1;
                check_idle_zero("rst_mid");
                @(posedge clk); #1;
                chk("rst_mid_no_done", 128'(obs_done), 128'(0));
                rst = 1'b0;
                rst_hit = 1;
                break;
            end
            acc = obs_v && out_ready;
            chk("done", 128'(obs_done), 128'(acc && k == total - 1));
            chk("busy_run", 128'(obs_busy), 128'(1));
            if (!out_ready && !rnd && stalled > 0)
                chk("stall_valid", 128'(obs_v), 128'(1));
            if (obs_v) begin
                if (first < 0) begin
                    first = cyc;
                    chk("latency", 128'(cyc), 128'(2));
                end
                sidx = k / bps;
                s = inv ? (nst - 1 - sidx) : sidx;
                c = k % bps;
                model(log_n, s, c, ema, ebn);
                chk("ma", obs_ma, ema);
                chk("bn", 128'(obs_bn), 128'(ebn));
                chk("last", 128'(obs_last), 128'(c == bps - 1));
                if (rnd) begin
                    seen = '0;
                    for (int j = 0; j < 16; j++) seen[obs_bn[j*4 +: 4]] = 1'b1;
                    chk("bn_perm", 128'(seen), 128'(16'hFFFF));
                end
                if (acc) begin
                    if (k == total - 1) begin
                        fin = 1;
                        done_cyc = cyc;
                    end
                    k++;
                end
            end
        end

        if (rst_hit) return;
        if (!fin) chk("timeout_beats", 128'(k), 128'(total));
        if (!rnd) chk("done_cycle", 128'(done_cyc), 128'(2 + total - 1 + stall_len));
        chk("beats_accepted", 128'(k), 128'(total));

        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        chk("busy_after_done", 128'(obs_busy), 128'(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_valid", 128'(obs_v), 128'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; #1; check_idle_zero("reset8");
        sel = 1'b1; #1; check_idle_zero("reset12");
        rst = 1'b0;

        run(1'b0, 1'b0, -1, 0, -1, 1'b0, 1'b0);   // forward, ready high
        run(1'b0, 1'b1, -1, 0, -1, 1'b0, 1'b0);   // inverse order
        run(1'b0, 1'b0, 20, 5, -1, 1'b0, 1'b0);   // 5-cycle stall mid-stage
        run(1'b0, 1'b0, -1, 0, 10, 1'b0, 1'b0);   // reset at beat 10
        run(1'b0, 1'b0, -1, 0, -1, 1'b0, 1'b0);   // clean rerun after reset
        run(1'b1, 1'b0, -1, 0, -1, 1'b1, 1'b1);   // 12-bit, random ready, start held
        run(1'b1, 1'b1, -1, 0, -1, 1'b1, 1'b0);   // 12-bit inverse, random ready

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agu_param_top.md
Name: agu_param_top

Overview:
- Parametrised address-generation unit for the NWC NTT datapath. It is the next generation of the fixed 16-lane AGU plus order-translate pair.
- Each beat it issues LANES conflict-free coefficient orders for the current butterfly stage. Each order is translated to a memory address (MA) and a bank number (BN).
- Adds forward/inverse stage ordering, a ready/valid output handshake with full backpressure, and per-stage last markers.
- Sits between the NTT controller (start/inverse) and the bank-switch / memory-array read ports.

Parameters:
- LOG_N, default 12: log2 of the point count N.
- LOG_L, default 4: log2 of the lane/bank count LANES = 2^LOG_L. LOG_N must be a multiple of LOG_L; elaboration fails otherwise.
- NUM_STG, derived as LOG_N/LOG_L: number of radix-LANES stages.
- MA_W, derived as LOG_N-LOG_L: width of each MA index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a full transform address sequence
- inverse  in  1  sampled with start; 1 selects reverse stage order
- out_ready  in  1  consumer accepts the current beat
- out_valid  out  1  ma_idx/bn_idx/out_last hold a valid beat
- ma_idx  out  LANES*MA_W  lane j occupies bits [j*MA_W +: MA_W]
- bn_idx  out  LANES*LOG_L  lane j occupies bits [j*LOG_L +: LOG_L]
- out_last  out  1  current beat is the final beat of its stage
- done  out  1  one-cycle pulse in the cycle the final beat of the final stage is accepted
- busy  out  1  high from the cycle after an accepted start until the cycle after done

Behaviour:
- Reset, asynchronous: all outputs are 0; the FSM is in IDLE; all counters and pipeline registers are 0.
- FSM states:
  - IDLE: start=1 latches inverse, sets stage = inverse ? NUM_STG-1 : 0, sets cnt = 0, and moves to RUN. start is ignored in any other state.
  - RUN: the generator advances one beat per cycle whenever the pipeline is not stalled.
    - cnt counts 0..N/LANES-1.
    - When cnt wraps, stage steps +1 (forward) or -1 (inverse).
    - After the last beat of the last stage is generated, move to DRAIN.
  - DRAIN: wait until the final beat is accepted (out_valid && out_ready && out_last on the final stage), pulse done, then return to IDLE.
- Order generation, for digits base LANES, with stage s, count c, lane j:
  - lo = c mod LANES^s
  - hi = c / LANES^s
  - idx = (hi << LOG_L*(s+1)) | (j << LOG_L*s) | lo
  - idx is LOG_N bits wide.
- Translation:
  - MA = idx >> LOG_L.
  - BN = sum of all NUM_STG LOG_L-bit digits of idx, mod LANES (wrap-around add).
  - Within one beat the lanes differ only in digit s, so the 16 BN values are a permutation of 0..LANES-1. Any duplicate BN within a beat is a bug.
- Pipeline: two register stages, generate then translate. The first out_valid appears 2 cycles after the start cycle, provided out_ready is held high.
- Stall: when out_valid=1 and out_ready=0, every pipeline register and the generator counters hold; outputs stay stable and no beat is dropped or duplicated.
- Bubbles: with out_valid=0, pipeline registers may advance regardless of out_ready.
- out_last = 1 exactly on the beat with cnt = N/LANES-1, once per stage.
- Throughput: one beat per cycle with out_ready held high. Total beats per run = NUM_STG*N/LANES.
- Reset asserted mid-run: immediate return to IDLE with outputs 0; no done pulse.
- start in the same cycle as done: ignored (the FSM is not yet in IDLE).

Test Plan:
1. LOG_N=8, LOG_L=4, start with inverse=0, out_ready=1:
   - out_valid rises at start+2.
   - Beat 0: MA=0 for all lanes; BN lane j = j.
   - 32 beats total; out_last on beats 15 and 31; done pulses on beat 31.
2. Same configuration, stage-1 beat cnt=1:
   - idx lane j = (j<<4)|1, so MA lane j = j and BN lane j = (j+1)%16.
3. inverse=1:
   - First 16 beats match the stage-1 pattern, the next 16 match stage 0.
   - done on beat 31.
4. Drop out_ready for 5 cycles mid-stage:
   - Outputs frozen; out_valid stays 1.
   - The accepted beat sequence is identical to test 1; done is delayed by exactly 5 cycles.
5. Pulse rst at beat 10:
   - All outputs 0 on the next edge; no done.
   - A subsequent start reproduces test 1 from beat 0.
6. Default LOG_N=12, LOG_L=4, random out_ready:
   - Scoreboard confirms every beat's BN set is a permutation of 0..15.
   - 768 beats accepted; busy falls one cycle after done.
